wb_commit_sched: RTL

- Commit scheduler between the dual-issue MEM_WB pipeline register and the architectural state (GPR file, CSR file, exception logic).
- Applies in-order commit rules to the two lines; line1 is always older than line2.
- Shares the single CSR write port between the two lines, serialising over two cycles when both lines write CSRs.
- Raises the pipeline flush on exceptions and keeps a retired-instruction counter.

---
 rtl/wb_commit_sched.sv | 87 ++++++++
 1 files changed

// File: rtl/wb_commit_sched.sv
// wb_commit_sched: in-order commit of the dual-issue MEM_WB pair to GPR/CSR state with exception flush
// Inputs : clk, rst_n (async, active-low), per-line valid / GPR write / CSR write / exception fields
// Outputs: allowin_o, rf_we_o/rf_waddr_o/rf_wdata_o ({line2,line1}), shared CSR port,
//          excep_flush_o/excep_ecode_o/excep_line_o, retire_cnt_o (registered)
module wb_commit_sched #(
   parameter int DATA_W  = 32,
   parameter int REG_AW  = 5,
   parameter int CSR_AW  = 14,
   parameter int ECODE_W = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  l1_valid_i,
   input  logic                  l2_valid_i,
   output logic                  allowin_o,
   input  logic                  l1_rf_we_i,
   input  logic                  l2_rf_we_i,
   input  logic [REG_AW-1:0]     l1_rf_waddr_i,
   input  logic [REG_AW-1:0]     l2_rf_waddr_i,
   input  logic [DATA_W-1:0]     l1_rf_wdata_i,
   input  logic [DATA_W-1:0]     l2_rf_wdata_i,
   input  logic                  l1_csr_we_i,
   input  logic                  l2_csr_we_i,
   input  logic [CSR_AW-1:0]     l1_csr_waddr_i,
   input  logic [CSR_AW-1:0]     l2_csr_waddr_i,
   input  logic [DATA_W-1:0]     l1_csr_wdata_i,
   input  logic [DATA_W-1:0]     l2_csr_wdata_i,
   input  logic                  l1_excep_i,
   input  logic                  l2_excep_i,
   input  logic [ECODE_W-1:0]    l1_ecode_i,
   input  logic [ECODE_W-1:0]    l2_ecode_i,
   output logic [1:0]            rf_we_o,
   output logic [2*REG_AW-1:0]   rf_waddr_o,
   output logic [2*DATA_W-1:0]   rf_wdata_o,
   output logic                  csr_we_o,
   output logic [CSR_AW-1:0]     csr_waddr_o,
   output logic [DATA_W-1:0]     csr_wdata_o,
   output logic                  excep_flush_o,
   output logic [ECODE_W-1:0]    excep_ecode_o,
   output logic                  excep_line_o,
   output logic [31:0]           retire_cnt_o
);
   localparam logic [1:0] S_IDLE = 2'd0, S_SER = 2'd1, S_FLUSH = 2'd2;
   logic [1:0]  r_state, w_next;
   logic [31:0] r_retire_cnt;
   logic w_idle, w_v1, w_v2, w_l1_ex, w_l2_ex, w_dual, w_c1, w_c2, w_l1_csr;
   assign w_idle  = r_state == S_IDLE;
   assign w_v1    = l1_valid_i;
   // an excepting line1 squashes line2
   assign w_v2    = l2_valid_i && !(w_v1 && l1_excep_i);
   assign w_l1_ex = w_idle && w_v1 && l1_excep_i;
   assign w_l2_ex = w_idle && w_v2 && l2_excep_i;
   assign w_dual  = w_idle && w_v1 && w_v2 && !l2_excep_i && l1_csr_we_i && l2_csr_we_i;
   // line commits this cycle; in SER only the held line2 commits
   assign w_c1    = w_idle && w_v1 && !l1_excep_i;
   assign w_c2    = (r_state == S_SER) || (w_idle && w_v2 && !l2_excep_i && !w_dual);
   assign w_l1_csr = w_c1 && l1_csr_we_i;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_retire_cnt <= '0;
      end else begin
         r_state      <= w_next;
         r_retire_cnt <= r_retire_cnt + 32'(w_c1) + 32'(w_c2);
      end
   always_comb begin
      w_next = S_IDLE;
      if (w_idle)
         w_next = (w_l1_ex || w_l2_ex) ? S_FLUSH : w_dual ? S_SER : S_IDLE;
   end
   always_comb begin
      rf_we_o[1]    = w_c2 && l2_rf_we_i;
      // same-cycle write to the same non-zero GPR: the younger line wins
      rf_we_o[0]    = w_c1 && l1_rf_we_i &&
                      !(rf_we_o[1] && l1_rf_waddr_i == l2_rf_waddr_i && l1_rf_waddr_i != '0);
      rf_waddr_o    = {l2_rf_waddr_i, l1_rf_waddr_i};
      rf_wdata_o    = {l2_rf_wdata_i, l1_rf_wdata_i};
      csr_we_o      = w_l1_csr || (w_c2 && l2_csr_we_i);
      csr_waddr_o   = w_l1_csr ? l1_csr_waddr_i : l2_csr_waddr_i;
      csr_wdata_o   = w_l1_csr ? l1_csr_wdata_i : l2_csr_wdata_i;
      excep_flush_o = w_l1_ex || w_l2_ex;
      excep_ecode_o = w_l1_ex ? l1_ecode_i : w_l2_ex ? l2_ecode_i : '0;
      excep_line_o  = w_l2_ex;
      allowin_o     = !w_dual;
      retire_cnt_o  = r_retire_cnt;
   end
endmodule
